// File: rtl/exu_muldiv_sched.sv
// M-extension issue scheduler: launches mul/div ops, tracks pending rd
// for hazard reporting, and arbitrates finished results onto one write port.
module exu_muldiv_sched #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid_i,
    input  logic [2:0]                req_op_i,
    input  logic [REG_DATA_WIDTH-1:0] req_rs1_i,
    input  logic [REG_DATA_WIDTH-1:0] req_rs2_i,
    input  logic [REG_ADDR_WIDTH-1:0] req_rd_i,
    output logic                      req_ready_o,
    input  logic                      flush_i,
    input  logic [REG_ADDR_WIDTH-1:0] chk_rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] chk_rs2_i,
    output logic                      hazard_o,
    output logic                      mul_start_o,
    output logic                      div_start_o,
    output logic [2:0]                mul_op_o,
    output logic [2:0]                div_op_o,
    output logic [REG_DATA_WIDTH-1:0] mul_multiplicand_o,
    output logic [REG_DATA_WIDTH-1:0] mul_multiplier_o,
    output logic [REG_DATA_WIDTH-1:0] div_dividend_o,
    output logic [REG_DATA_WIDTH-1:0] div_divisor_o,
    input  logic                      mul_busy_i,
    input  logic                      div_busy_i,
    input  logic                      mul_ready_i,
    input  logic                      div_ready_i,
    input  logic [REG_DATA_WIDTH-1:0] mul_result_i,
    input  logic [REG_DATA_WIDTH-1:0] div_result_i,
    output logic                      wb_valid_o,
    output logic [REG_ADDR_WIDTH-1:0] wb_waddr_o,
    output logic [REG_DATA_WIDTH-1:0] wb_wdata_o,
    input  logic                      wb_ready_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DONE,
        S_DRAIN
    } slot_state_e;

    localparam int MUL = 0;
    localparam int DIV = 1;

    slot_state_e               state_q [2];
    slot_state_e               state_d [2];
    logic [2:0]                op_q    [2];
    logic [REG_DATA_WIDTH-1:0] opa_q   [2];
    logic [REG_DATA_WIDTH-1:0] opb_q   [2];
    logic [REG_DATA_WIDTH-1:0] res_q   [2];
    logic [REG_ADDR_WIDTH-1:0] rd_q    [2];
    logic [REG_DATA_WIDTH-1:0] unit_result [2];

    logic       last_q;
    logic       hold_q;
    logic       hold_sel_q;
    logic [1:0] unit_ready;
    logic [1:0] pending;
    logic [1:0] done;
    logic [1:0] accept;
    logic [1:0] grant;
    logic       tgt;
    logic       other;
    logic       waw;
    logic       sel;
    logic       any_done;
    logic       wb_grant;
    logic       unused_busy;

    assign unused_busy    = mul_busy_i ^ div_busy_i;
    assign unit_ready     = {div_ready_i, mul_ready_i};
    assign unit_result[0] = mul_result_i;
    assign unit_result[1] = div_result_i;
    assign tgt            = req_op_i[2];
    assign other          = ~req_op_i[2];

    // Slot status, request admission and writeback arbitration
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            pending[i] = (state_q[i] == S_LAUNCH || state_q[i] == S_RUN ||
                          state_q[i] == S_DONE) && (rd_q[i] != '0);
            done[i]    = (state_q[i] == S_DONE);
        end
        waw         = (req_rd_i != '0) && pending[other] &&
                      (rd_q[other] == req_rd_i);
        req_ready_o = (state_q[tgt] == S_IDLE) && !flush_i && !waw;
        accept      = {req_valid_i & req_ready_o & tgt,
                       req_valid_i & req_ready_o & ~tgt};
        any_done    = |done;
        // A stalled offer stays locked so wb_* cannot change under it
        if (hold_q)
            sel = hold_sel_q;
        else if (&done)
            sel = ~last_q;
        else
            sel = done[DIV];
        wb_valid_o  = any_done && !flush_i;
        wb_grant    = wb_valid_o && wb_ready_i;
        grant       = {wb_grant & sel, wb_grant & ~sel};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++)
                state_q[i] <= S_IDLE;
        end else begin
            for (int i = 0; i < 2; i++)
                state_q[i] <= state_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                S_IDLE: begin
                    if (accept[i])
                        state_d[i] = S_LAUNCH;
                end
                S_LAUNCH: begin
                    state_d[i] = flush_i ? S_IDLE : S_RUN;
                end
                S_RUN: begin
                    if (unit_ready[i])
                        state_d[i] = (flush_i || rd_q[i] == '0) ? S_IDLE : S_DONE;
                    else if (flush_i)
                        state_d[i] = S_DRAIN;
                end
                S_DONE: begin
                    if (flush_i || grant[i])
                        state_d[i] = S_IDLE;
                end
                S_DRAIN: begin
                    if (unit_ready[i])
                        state_d[i] = S_IDLE;
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                op_q[i]  <= '0;
                opa_q[i] <= '0;
                opb_q[i] <= '0;
                res_q[i] <= '0;
                rd_q[i]  <= '0;
            end
            last_q     <= 1'b0;
            hold_q     <= 1'b0;
            hold_sel_q <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (accept[i]) begin
                    op_q[i]  <= req_op_i;
                    opa_q[i] <= req_rs1_i;
                    opb_q[i] <= req_rs2_i;
                    rd_q[i]  <= req_rd_i;
                end
                if (state_q[i] == S_RUN && unit_ready[i] && !flush_i)
                    res_q[i] <= unit_result[i];
            end
            if (wb_grant)
                last_q <= sel;
            hold_q     <= wb_valid_o && !wb_ready_i;
            hold_sel_q <= sel;
        end
    end

    always_comb begin
        mul_start_o        = (state_q[MUL] == S_LAUNCH) && !flush_i;
        div_start_o        = (state_q[DIV] == S_LAUNCH) && !flush_i;
        mul_op_o           = op_q[MUL];
        div_op_o           = op_q[DIV];
        mul_multiplicand_o = opa_q[MUL];
        mul_multiplier_o   = opb_q[MUL];
        div_dividend_o     = opa_q[DIV];
        div_divisor_o      = opb_q[DIV];
        wb_waddr_o         = any_done ? rd_q[sel] : '0;
        wb_wdata_o         = any_done ? res_q[sel] : '0;
        hazard_o           = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (pending[i] &&
                ((chk_rs1_i != '0 && chk_rs1_i == rd_q[i]) ||
                 (chk_rs2_i != '0 && chk_rs2_i == rd_q[i])))
                hazard_o = 1'b1;
        end
    end

endmodule

// File: tb/tb_exu_muldiv_sched.sv
// Directed bench for exu_muldiv_sched: issue, hazards, arbitration,
// WAW blocking, flush/drain, writeback stall and mid-run reset.
module tb_exu_muldiv_sched;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic [2:0]  req_op_i;
    logic [31:0] req_rs1_i;
    logic [31:0] req_rs2_i;
    logic [4:0]  req_rd_i;
    logic        req_ready_o;
    logic        flush_i;
    logic [4:0]  chk_rs1_i;
    logic [4:0]  chk_rs2_i;
    logic        hazard_o;
    logic        mul_start_o;
    logic        div_start_o;
    logic [2:0]  mul_op_o;
    logic [2:0]  div_op_o;
    logic [31:0] mul_multiplicand_o;
    logic [31:0] mul_multiplier_o;
    logic [31:0] div_dividend_o;
    logic [31:0] div_divisor_o;
    logic        mul_busy_i;
    logic        div_busy_i;
    logic        mul_ready_i;
    logic        div_ready_i;
    logic [31:0] mul_result_i;
    logic [31:0] div_result_i;
    logic        wb_valid_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;
    logic        wb_ready_i;

    int pass_cnt = 0;
    int total_cnt = 0;

    exu_muldiv_sched #(
        .REG_DATA_WIDTH(32),
        .REG_ADDR_WIDTH(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid_i(req_valid_i),
        .req_op_i(req_op_i),
        .req_rs1_i(req_rs1_i),
        .req_rs2_i(req_rs2_i),
        .req_rd_i(req_rd_i),
        .req_ready_o(req_ready_o),
        .flush_i(flush_i),
        .chk_rs1_i(chk_rs1_i),
        .chk_rs2_i(chk_rs2_i),
        .hazard_o(hazard_o),
        .mul_start_o(mul_start_o),
        .div_start_o(div_start_o),
        .mul_op_o(mul_op_o),
        .div_op_o(div_op_o),
        .mul_multiplicand_o(mul_multiplicand_o),
        .mul_multiplier_o(mul_multiplier_o),
        .div_dividend_o(div_dividend_o),
        .div_divisor_o(div_divisor_o),
        .mul_busy_i(mul_busy_i),
        .div_busy_i(div_busy_i),
        .mul_ready_i(mul_ready_i),
        .div_ready_i(div_ready_i),
        .mul_result_i(mul_result_i),
        .div_result_i(div_result_i),
        .wb_valid_o(wb_valid_o),
        .wb_waddr_o(wb_waddr_o),
        .wb_wdata_o(wb_wdata_o),
        .wb_ready_i(wb_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid_i  = 1'b0;
        req_op_i     = 3'b000;
        req_rs1_i    = '0;
        req_rs2_i    = '0;
        req_rd_i     = '0;
        flush_i      = 1'b0;
        chk_rs1_i    = '0;
        chk_rs2_i    = '0;
        mul_busy_i   = 1'b0;
        div_busy_i   = 1'b0;
        mul_ready_i  = 1'b0;
        div_ready_i  = 1'b0;
        mul_result_i = '0;
        div_result_i = '0;
        wb_ready_i   = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        total_cnt++;
        if (req_ready_o !== 1'b1) $display("FAIL reset_ready got %0b exp 1", req_ready_o);
        else pass_cnt++;
        total_cnt++;
        if ({mul_start_o, div_start_o, hazard_o, wb_valid_o} !== 4'b0)
            $display("FAIL reset_ctrl got %b exp 0000",
                     {mul_start_o, div_start_o, hazard_o, wb_valid_o});
        else pass_cnt++;
        total_cnt++;
        if (wb_waddr_o !== 5'd0 || wb_wdata_o !== 32'd0 || mul_multiplicand_o !== 32'd0 ||
            div_divisor_o !== 32'd0 || mul_op_o !== 3'd0)
            $display("FAIL reset_data got waddr %0h wdata %0h mcand %0h dvsr %0h exp 0",
                     wb_waddr_o, wb_wdata_o, mul_multiplicand_o, div_divisor_o);
        else pass_cnt++;
    endtask

    task automatic test_single_mul();
        req_valid_i = 1'b1;
        req_op_i = 3'b000;
        req_rs1_i = 32'd7;
        req_rs2_i = 32'd6;
        req_rd_i = 5'd5;
        #1;
        total_cnt++;
        if (req_ready_o !== 1'b1) $display("FAIL mul_accept got %0b exp 1", req_ready_o);
        else pass_cnt++;
        tick();
        req_valid_i = 1'b0;
        chk_rs1_i = 5'd5;
        #1;
        total_cnt++;
        if (mul_start_o !== 1'b1 || mul_multiplicand_o !== 32'd7 || mul_multiplier_o !== 32'd6)
            $display("FAIL mul_launch got start %0b a %0d b %0d exp 1 7 6",
                     mul_start_o, mul_multiplicand_o, mul_multiplier_o);
        else pass_cnt++;
        total_cnt++;
        if (hazard_o !== 1'b1) $display("FAIL mul_hazard_launch got %0b exp 1", hazard_o);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (mul_start_o !== 1'b0 || hazard_o !== 1'b1)
            $display("FAIL mul_run got start %0b hz %0b exp 0 1", mul_start_o, hazard_o);
        else pass_cnt++;
        tick();
        tick();
        mul_ready_i = 1'b1;
        mul_result_i = 32'd42;
        #1;
        total_cnt++;
        if (wb_valid_o !== 1'b0) $display("FAIL mul_wb_early got %0b exp 0", wb_valid_o);
        else pass_cnt++;
        tick();
        mul_ready_i = 1'b0;
        #1;
        total_cnt++;
        if (wb_valid_o !== 1'b1 || wb_waddr_o !== 5'd5 || wb_wdata_o !== 32'd42 || hazard_o !== 1'b1)
            $display("FAIL mul_wb got v %0b a %0d d %0d hz %0b exp 1 5 42 1",
                     wb_valid_o, wb_waddr_o, wb_wdata_o, hazard_o);
        else pass_cnt++;
        wb_ready_i = 1'b1;
        tick();
        wb_ready_i = 1'b0;
        chk_rs1_i = 5'd0;
        chk_rs2_i = 5'd5;
        #1;
        total_cnt++;
        if (wb_valid_o !== 1'b0 || hazard_o !== 1'b0)
            $display("FAIL mul_after_grant got v %0b hz %0b exp 0 0", wb_valid_o, hazard_o);
        else pass_cnt++;
        chk_rs2_i = 5'd0;
    endtask

    task automatic test_tie();
        // round A: previous grant was MUL, so DIV wins; MUL result flushed
        req_valid_i = 1'b1;
        req_op_i = 3'b000;
        req_rs1_i = 32'd2;
        req_rs2_i = 32'd3;
        req_rd_i = 5'd3;
        tick();
        req_op_i = 3'b100;
        req_rs1_i = 32'd100;
        req_rs2_i = 32'd5;
        req_rd_i = 5'd4;
        #1;
        total_cnt++;
        if (req_ready_o !== 1'b1) $display("FAIL tie_div_accept got %0b exp 1", req_ready_o);
        else pass_cnt++;
        tick();
        req_valid_i = 1'b0;
        #1;
        total_cnt++;
        if (div_start_o !== 1'b1 || div_dividend_o !== 32'd100 || div_divisor_o !== 32'd5 ||
            div_op_o !== 3'b100)
            $display("FAIL tie_div_launch got start %0b a %0d b %0d op %0d exp 1 100 5 4",
                     div_start_o, div_dividend_o, div_divisor_o, div_op_o);
        else pass_cnt++;
        tick();
        mul_ready_i = 1'b1;
        mul_result_i = 32'd6;
        div_ready_i = 1'b1;
        div_result_i = 32'd20;
        wb_ready_i = 1'b1;
        tick();
        mul_ready_i = 1'b0;
        div_ready_i = 1'b0;
        #1;
        total_cnt++;
        if (wb_valid_o !== 1'b1 || wb_waddr_o !== 5'd4 || wb_wdata_o !== 32'd20)
            $display("FAIL tie_a_first got v %0b a %0d d %0d exp 1 4 20",
                     wb_valid_o, wb_waddr_o, wb_wdata_o);
        else pass_cnt++;
        tick();
        flush_i = 1'b1;
        #1;
        total_cnt++;
        if (wb_valid_o !== 1'b0 || req_ready_o !== 1'b0)
            $display("FAIL tie_a_flush got v %0b rdy %0b exp 0 0", wb_valid_o, req_ready_o);
        else pass_cnt++;
        tick();
        flush_i = 1'b0;
        #1;
        total_cnt++;
        if (wb_valid_o !== 1'b0) $display("FAIL tie_a_dropped got %0b exp 0", wb_valid_o);
        else pass_cnt++;
        // round B: previous grant was DIV, so MUL wins, DIV next cycle
        req_valid_i = 1'b1;
        req_op_i = 3'b000;
        req_rd_i = 5'd10;
        tick();
        req_op_i = 3'b101;
        req_rd_i = 5'd12;
        tick();
        req_valid_i = 1'b0;
        tick();
        mul_ready_i = 1'b1;
        mul_result_i = 32'd11;
        div_ready_i = 1'b1;
        div_result_i = 32'd13;
        tick();
        mul_ready_i = 1'b0;
        div_ready_i = 1'b0;
        #1;
        total_cnt++;
        if (wb_valid_o !== 1'b1 || wb_waddr_o !== 5'd10 || wb_wdata_o !== 32'd11)
            $display("FAIL tie_b_first got v %0b a %0d d %0d exp 1 10 11",
                     wb_valid_o, wb_waddr_o, wb_wdata_o);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (wb_valid_o !== 1'b1 || wb_waddr_o !== 5'd12 || wb_wdata_o !== 32'd13)
            $display("FAIL tie_b_second got v %0b a %0d d %0d exp 1 12 13",
                     wb_valid_o, wb_waddr_o, wb_wdata_o);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (wb_valid_o !== 1'b0) $display("FAIL tie_b_empty got %0b exp 0", wb_valid_o);
        else pass_cnt++;
        wb_ready_i = 1'b0;
    endtask

    task automatic test_waw();
        req_valid_i = 1'b1;
        req_op_i = 3'b000;
        req_rs1_i = 32'd9;
        req_rs2_i = 32'd11;
        req_rd_i = 5'd8;
        tick();
        req_valid_i = 1'b0;
        req_op_i = 3'b100;
        #1;
        total_cnt++;
        if (req_ready_o !== 1'b0) $display("FAIL waw_launch got %0b exp 0", req_ready_o);
        else pass_cnt++;
        req_rd_i = 5'd9;
        #1;
        total_cnt++;
        if (req_ready_o !== 1'b1) $display("FAIL waw_other_rd got %0b exp 1", req_ready_o);
        else pass_cnt++;
        req_rd_i = 5'd8;
        tick();
        mul_ready_i = 1'b1;
        mul_result_i = 32'd99;
        #1;
        total_cnt++;
        if (req_ready_o !== 1'b0) $display("FAIL waw_run got %0b exp 0", req_ready_o);
        else pass_cnt++;
        tick();
        mul_ready_i = 1'b0;
        #1;
        total_cnt++;
        if (req_ready_o !== 1'b0 || wb_valid_o !== 1'b1 || wb_waddr_o !== 5'd8)
            $display("FAIL waw_done got rdy %0b v %0b a %0d exp 0 1 8",
                     req_ready_o, wb_valid_o, wb_waddr_o);
        else pass_cnt++;
        wb_ready_i = 1'b1;
        tick();
        wb_ready_i = 1'b0;
        req_rs1_i = 32'd50;
        req_rs2_i = 32'd7;
        #1;
        total_cnt++;
        if (req_ready_o !== 1'b1) $display("FAIL waw_release got %0b exp 1", req_ready_o);
        else pass_cnt++;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        #1;
        total_cnt++;
        if (div_start_o !== 1'b1 || div_dividend_o !== 32'd50 || div_op_o !== 3'b100)
            $display("FAIL waw_div_launch got start %0b a %0d op %0d exp 1 50 4",
                     div_start_o, div_dividend_o, div_op_o);
        else pass_cnt++;
        tick();
        div_ready_i = 1'b1;
        div_result_i = 32'd7;
        tick();
        div_ready_i = 1'b0;
        #1;
        total_cnt++;
        if (wb_valid_o !== 1'b1 || wb_waddr_o !== 5'd8 || wb_wdata_o !== 32'd7)
            $display("FAIL waw_div_wb got v %0b a %0d d %0d exp 1 8 7",
                     wb_valid_o, wb_waddr_o, wb_wdata_o);
        else pass_cnt++;
        wb_ready_i = 1'b1;
        tick();
        wb_ready_i = 1'b0;
    endtask

    task automatic test_flush_drain();
        req_valid_i = 1'b1;
        req_op_i = 3'b110;
        req_rs1_i = 32'd20;
        req_rs2_i = 32'd3;
        req_rd_i = 5'd7;
        tick();
        req_valid_i = 1'b0;
        tick();
        flush_i = 1'b1;
        req_op_i = 3'b000;
        req_rd_i = 5'd1;
        #1;
        total_cnt++;
        if (req_ready_o !== 1'b0) $display("FAIL flush_refuse got %0b exp 0", req_ready_o);
        else pass_cnt++;
        tick();
        flush_i = 1'b0;
        req_op_i = 3'b100;
        req_rd_i = 5'd11;
        chk_rs1_i = 5'd7;
        #1;
        total_cnt++;
        if (req_ready_o !== 1'b0 || hazard_o !== 1'b0)
            $display("FAIL drain_state got rdy %0b hz %0b exp 0 0", req_ready_o, hazard_o);
        else pass_cnt++;
        tick();
        div_ready_i = 1'b1;
        div_result_i = 32'd55;
        #1;
        total_cnt++;
        if (req_ready_o !== 1'b0) $display("FAIL drain_pulse got %0b exp 0", req_ready_o);
        else pass_cnt++;
        tick();
        div_ready_i = 1'b0;
        chk_rs1_i = 5'd0;
        req_rs1_i = 32'd40;
        req_rs2_i = 32'd8;
        #1;
        total_cnt++;
        if (req_ready_o !== 1'b1 || wb_valid_o !== 1'b0)
            $display("FAIL drain_done got rdy %0b v %0b exp 1 0", req_ready_o, wb_valid_o);
        else pass_cnt++;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        #1;
        total_cnt++;
        if (div_start_o !== 1'b1 || div_dividend_o !== 32'd40)
            $display("FAIL drain_relaunch got start %0b a %0d exp 1 40", div_start_o, div_dividend_o);
        else pass_cnt++;
        tick();
        div_ready_i = 1'b1;
        div_result_i = 32'd5;
        tick();
        div_ready_i = 1'b0;
        #1;
        total_cnt++;
        if (wb_valid_o !== 1'b1 || wb_waddr_o !== 5'd11 || wb_wdata_o !== 32'd5)
            $display("FAIL drain_wb got v %0b a %0d d %0d exp 1 11 5",
                     wb_valid_o, wb_waddr_o, wb_wdata_o);
        else pass_cnt++;
        wb_ready_i = 1'b1;
        tick();
        wb_ready_i = 1'b0;
    endtask

    task automatic test_stall();
        req_valid_i = 1'b1;
        req_op_i = 3'b000;
        req_rs1_i = 32'd2;
        req_rs2_i = 32'h91a;
        req_rd_i = 5'd6;
        tick();
        req_valid_i = 1'b0;
        tick();
        mul_ready_i = 1'b1;
        mul_result_i = 32'h1234;
        tick();
        mul_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            req_valid_i = 1'b0;
            div_ready_i = (k == 2);
            div_result_i = 32'd77;
            #1;
            total_cnt++;
            if (wb_valid_o !== 1'b1 || wb_waddr_o !== 5'd6 || wb_wdata_o !== 32'h1234)
                $display("FAIL stall_hold%0d got v %0b a %0d d %0h exp 1 6 1234",
                         k, wb_valid_o, wb_waddr_o, wb_wdata_o);
            else pass_cnt++;
            if (k == 0) begin
                req_op_i = 3'b000;
                req_rd_i = 5'd1;
                #1;
                total_cnt++;
                if (req_ready_o !== 1'b0) $display("FAIL stall_mul_refuse got %0b exp 1'b0", req_ready_o);
                else pass_cnt++;
                req_op_i = 3'b101;
                req_rd_i = 5'd0;
                req_valid_i = 1'b1;
                #1;
                total_cnt++;
                if (req_ready_o !== 1'b1) $display("FAIL stall_div_accept got %0b exp 1", req_ready_o);
                else pass_cnt++;
            end
            if (k == 1) begin
                total_cnt++;
                if (div_start_o !== 1'b1) $display("FAIL stall_div_start got %0b exp 1", div_start_o);
                else pass_cnt++;
            end
            if (k == 4) begin
                req_op_i = 3'b100;
                #1;
                total_cnt++;
                if (req_ready_o !== 1'b1) $display("FAIL stall_div_idle got %0b exp 1", req_ready_o);
                else pass_cnt++;
            end
            tick();
        end
        div_ready_i = 1'b0;
        wb_ready_i = 1'b1;
        tick();
        wb_ready_i = 1'b0;
        #1;
        total_cnt++;
        if (wb_valid_o !== 1'b0) $display("FAIL stall_rd0_no_wb got %0b exp 0", wb_valid_o);
        else pass_cnt++;
    endtask

    task automatic test_rst_mid();
        req_valid_i = 1'b1;
        req_op_i = 3'b000;
        req_rs1_i = 32'd3;
        req_rs2_i = 32'd4;
        req_rd_i = 5'd2;
        tick();
        req_valid_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_rs1_i = 5'd2;
        mul_ready_i = 1'b1;
        mul_result_i = 32'd12;
        #1;
        total_cnt++;
        if (mul_multiplicand_o !== 32'd0 || mul_multiplier_o !== 32'd0 || mul_start_o !== 1'b0 ||
            hazard_o !== 1'b0 || wb_valid_o !== 1'b0 || req_ready_o !== 1'b1)
            $display("FAIL rst_mid got a %0d b %0d st %0b hz %0b v %0b rdy %0b exp 0 0 0 0 0 1",
                     mul_multiplicand_o, mul_multiplier_o, mul_start_o, hazard_o,
                     wb_valid_o, req_ready_o);
        else pass_cnt++;
        tick();
        mul_ready_i = 1'b0;
        #1;
        total_cnt++;
        if (wb_valid_o !== 1'b0 || wb_wdata_o !== 32'd0 || hazard_o !== 1'b0)
            $display("FAIL rst_stray got v %0b d %0d hz %0b exp 0 0 0",
                     wb_valid_o, wb_wdata_o, hazard_o);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_mul();
        test_tie();
        test_waw();
        test_flush_drain();
        test_stall();
        test_rst_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/exu_muldiv_sched.md
# exu_muldiv_sched

Issue scheduler and writeback arbiter sitting between the EXU decode stage and the shared multi-cycle multiplier and divider. It accepts M-extension requests, launches at most one multiply and one divide concurrently, and tracks their destination registers for RAW/WAW hazard reporting. It buffers finished results and arbitrates them onto a single register-file write port.

## Interface
- `REG_DATA_WIDTH`, 32, operand/result width
- `REG_ADDR_WIDTH`, 5, register address width
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid_i`  in  1  M-extension request valid
- `req_op_i`  in  3  funct3; bit2=0 multiply, bit2=1 divide/remainder
- `req_rs1_i` / `req_rs2_i`  in  REG_DATA_WIDTH  operand values
- `req_rd_i`  in  REG_ADDR_WIDTH  destination register
- `req_ready_o`  out  1  request accepted when valid&ready
- `flush_i`  in  1  interrupt/redirect; cancels all in-flight work
- `chk_rs1_i` / `chk_rs2_i`  in  REG_ADDR_WIDTH  source addresses of instruction in decode
- `hazard_o`  out  1  a chk address matches a pending rd
- `mul_start_o` / `div_start_o`  out  1  one-cycle launch pulse
- `mul_op_o` / `div_op_o`  out  3  latched funct3
- `mul_multiplicand_o`, `mul_multiplier_o`, `div_dividend_o`, `div_divisor_o`  out  REG_DATA_WIDTH  latched operands
- `mul_busy_i` / `div_busy_i`  in  1  unit busy (informational only)
- `mul_ready_i` / `div_ready_i`  in  1  one-cycle result-valid pulse
- `mul_result_i` / `div_result_i`  in  REG_DATA_WIDTH  unit result
- `wb_valid_o`  out  1  writeback request
- `wb_waddr_o`  out  REG_ADDR_WIDTH  writeback address
- `wb_wdata_o`  out  REG_DATA_WIDTH  writeback data
- `wb_ready_i`  in  1  write port granted

## Operation
- Two identical slots (MUL, DIV), each FSM: IDLE, LAUNCH, RUN, DONE, DRAIN.
- Target slot = `req_op_i[2]`. `req_ready_o` = target slot IDLE & !flush_i & !(req_rd_i≠0 & req_rd_i equals other slot's pending rd) (WAW block).
- Accept: latch op, operands, rd; IDLE→LAUNCH.
- LAUNCH: `*_start_o`=1 for exactly this cycle; →RUN.
- RUN: on unit ready pulse, capture result; rd≠0 →DONE, rd=0 →IDLE (no writeback).
- DONE: holds result until granted; grant → IDLE.
- Pending rd: slot in LAUNCH/RUN/DONE with rd≠0. `hazard_o` combinational: (chk_rs1_i or chk_rs2_i) ≠0 and equals any pending rd.
- Writeback arbitration: only DONE slots request. One DONE → it is offered. Both DONE → round-robin by last-granted bit (reset value: MUL last granted, so DIV wins first tie). Offered slot's rd/data drive wb_*; grant = wb_valid_o & wb_ready_i; last-granted updates only on grant.
- wb_* outputs stable while wb_valid_o high and not granted, unless flush.
- Flush: LAUNCH→IDLE (start suppressed), RUN→DRAIN, DONE→IDLE (result dropped), IDLE unchanged. DRAIN: wait for unit ready pulse, discard result, →IDLE; flush_i in DRAIN keeps DRAIN. No request accepted in the flush cycle.
- DRAIN slot is not pending (no hazard) but not IDLE (blocks new requests to that unit).
- Ready pulse with slot in IDLE/LAUNCH/DONE: ignored.

## Timing
- Reset: all FSMs IDLE; req_ready_o follows IDLE combinationally (1 when !flush_i); mul/div_start_o=0, op/operand outputs 0, hazard_o=0 (no pending), wb_valid_o=0, wb_waddr_o=0, wb_wdata_o=0, last-granted=MUL.
- Accept in cycle N → start pulse in N+1 with operands valid → RUN from N+2.
- Unit ready in cycle M → wb_valid_o in M+1 (registered result; no combinational ready→wb path).
- Grant in cycle G → slot IDLE in G+1; req_ready_o for that unit may assert in G+1.
- Minimum accept→writeback: ready at N+2 ⇒ wb_valid_o at N+3.
- Mul and div may be accepted in consecutive cycles; one accept per cycle max (single request port).
- Simultaneous flush and grant: flush wins, no write performed (wb_valid_o deasserted combinationally by flush_i).
- Simultaneous ready pulses from both units: both captured; writebacks in consecutive cycles per round-robin.

## Test plan
- Single MUL rd=5, operands 7,6: start pulse N+1 with 7,6; unit ready at N+4 with 42 → wb_valid_o at N+5, waddr=5, wdata=42; hazard_o=1 for chk_rs1_i=5 from N+1 through grant.
- MUL rd=3 and DIV rd=4 both finish same cycle, wb_ready_i=1: DIV written first cycle, MUL next; next tie grants MUL first.
- WAW: MUL rd=8 pending, DIV request rd=8 → req_ready_o=0 until MUL granted; DIV rd=9 accepted immediately.
- Flush while DIV in RUN: no writeback; DIV request refused until div_ready_i pulse drains; accepted cycle after.
- wb_ready_i held 0 for 5 cycles with MUL in DONE: wb_* stable, new MUL request refused, DIV accepted; rd=0 request completes with no wb_valid_o.
- rst asserted mid-RUN: next cycle all outputs at reset values; subsequent stray ready pulse ignored.
